pc_fetch_ctrl: RTL and testbench

- Upstream neighbour of the IF/ID fetch pipeline register.
- Owns the program counter and issues single-outstanding requests to instruction memory.
- Handles jal/jalr/branch redirects and load-use stalls.
- Drives the registered pre_address_pc / instruction_fetch pair that the IF/ID register consumes.

---
 rtl/pc_fetch_ctrl_pkg.sv | 14 +
 rtl/pc_fetch_ctrl_if.sv | 10 +
 rtl/pc_fetch_ctrl_pc_next_sel.sv | 31 +++
 rtl/pc_fetch_ctrl.sv | 107 ++++++++++
 tb/tb_pc_fetch_ctrl.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the fetch front end.
package rv32i_fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_BUBBLE_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction memory request/response bundle; master is the fetch controller.
interface pc_fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;

    modport master (output imem_req, output imem_addr, input imem_rdata, input imem_valid);
    modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_valid);
endinterface

// File: rtl/pc_fetch_ctrl_pc_next_sel.sv
// Next pc / request address selection: aligned redirect, sequential step, or hold.
module pc_next_sel
    import rv32i_fetch_pkg::*;
(
    input  logic        redirect,
    input  logic        advance,
    input  logic [31:0] target,
    input  logic [31:0] pc,
    input  logic [31:0] req_addr,
    output logic [31:0] pc_nxt,
    output logic [31:0] req_nxt
);
    logic [31:0] target_aligned;
    logic [31:0] step_addr;

    assign target_aligned = target & ~32'h3;
    // Wraps silently at the top of the address space.
    assign step_addr      = req_addr + PC_STEP;

    always_comb begin
        pc_nxt  = pc;
        req_nxt = req_addr;
        if (redirect) begin
            pc_nxt  = target_aligned;
            req_nxt = target_aligned;
        end else if (advance) begin
            pc_nxt  = step_addr;
            req_nxt = step_addr;
        end
    end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and single-outstanding instruction fetch controller feeding IF/ID.
// Optional performance counters enabled by defining PC_FETCH_PERF_EN.
module pc_fetch_ctrl
    import rv32i_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] BUBBLE_INSTR = DEF_BUBBLE_INSTR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 next_select,
    input  logic                 branch_result,
    input  logic [31:0]          redirect_target,
    pc_fetch_ctrl_if.master      imem,
    output logic [31:0]          pre_address_pc,
    output logic [31:0]          instruction_fetch,
    output logic                 fetch_valid
`ifdef PC_FETCH_PERF_EN
    ,
    output logic [31:0]          perf_fetch_cnt,
    output logic [31:0]          perf_stall_cnt
`endif
);
    fetch_state_e state;
    logic [31:0]  pc, req_addr, drain_addr;
    logic [31:0]  pc_nxt, req_nxt;
    logic         redirect, advance;

    assign redirect = (state != BOOT) && (next_select || branch_result);
    assign advance  = (state == FETCH) && !redirect && !load && imem.imem_valid;

    pc_next_sel u_next_sel (
        .redirect (redirect),
        .advance  (advance),
        .target   (redirect_target),
        .pc       (pc),
        .req_addr (req_addr),
        .pc_nxt   (pc_nxt),
        .req_nxt  (req_nxt)
    );

    // Request side depends only on state registers, never on imem_valid.
    assign imem.imem_req  = (state != BOOT);
    assign imem.imem_addr = (state == DRAIN) ? drain_addr : req_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= BOOT;
            pc                <= RESET_VECTOR;
            req_addr          <= RESET_VECTOR;
            drain_addr        <= RESET_VECTOR;
            pre_address_pc    <= 32'h0;
            instruction_fetch <= BUBBLE_INSTR;
            fetch_valid       <= 1'b0;
        end else begin
            pc       <= pc_nxt;
            req_addr <= req_nxt;
            case (state)
                BOOT: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (redirect) begin
                        pre_address_pc    <= 32'h0;
                        instruction_fetch <= BUBBLE_INSTR;
                        fetch_valid       <= 1'b0;
                        // The outstanding response must be swallowed before the new target.
                        if (!imem.imem_valid) begin
                            state      <= DRAIN;
                            drain_addr <= req_addr;
                        end
                    end else if (load) begin
                        pre_address_pc    <= pre_address_pc;
                    end else if (imem.imem_valid) begin
                        pre_address_pc    <= req_addr;
                        instruction_fetch <= imem.imem_rdata;
                        fetch_valid       <= 1'b1;
                    end else begin
                        pre_address_pc    <= 32'h0;
                        instruction_fetch <= BUBBLE_INSTR;
                        fetch_valid       <= 1'b0;
                    end
                end
                DRAIN: begin
                    pre_address_pc    <= 32'h0;
                    instruction_fetch <= BUBBLE_INSTR;
                    fetch_valid       <= 1'b0;
                    if (imem.imem_valid) state <= FETCH;
                end
                default: state <= BOOT;
            endcase
        end
    end

`ifdef PC_FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= 32'h0;
            perf_stall_cnt <= 32'h0;
        end else begin
            if (advance) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (load || state == DRAIN) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a latency-programmable instruction memory.
module tb_pc_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        load, next_select, branch_result;
    logic [31:0] redirect_target;
    logic [31:0] pre_address_pc, instruction_fetch;
    logic        fetch_valid;
`ifdef PC_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    int n_chk = 0;
    int n_fail = 0;

    // Memory model: response after lat cycles of request; force_vld fakes a late response.
    int          lat;
    logic        force_vld;
    logic [31:0] cnt;

    pc_fetch_ctrl_if mem ();

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    assign mem.imem_rdata = memw(mem.imem_addr);
    assign mem.imem_valid = force_vld || (mem.imem_req && (cnt == 32'(lat - 1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= 32'h0;
        else if (mem.imem_req && !mem.imem_valid) cnt <= cnt + 32'd1;
        else cnt <= 32'h0;
    end

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .load              (load),
        .next_select       (next_select),
        .branch_result     (branch_result),
        .redirect_target   (redirect_target),
        .imem              (mem.master),
        .pre_address_pc    (pre_address_pc),
        .instruction_fetch (instruction_fetch),
        .fetch_valid       (fetch_valid)
`ifdef PC_FETCH_PERF_EN
        ,
        .perf_fetch_cnt    (perf_fetch_cnt),
        .perf_stall_cnt    (perf_stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; next_select = 1'b0; branch_result = 1'b0;
        redirect_target = 32'h0; lat = 1; force_vld = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(mem.imem_req), 32'h0);
        chk("rst_fv",  32'(fetch_valid), 32'h0);
        chk("rst_pre", pre_address_pc, 32'h0);
        chk("rst_ins", instruction_fetch, 32'h0);
        rst = 1'b0;
        #1 chk("boot_req", 32'(mem.imem_req), 32'h0);

        // Zero-wait sequential fetch
        @(negedge clk);
        chk("f0_req",  32'(mem.imem_req), 32'h1);
        chk("f0_addr", mem.imem_addr, 32'h0);
        chk("f0_fv",   32'(fetch_valid), 32'h0);
        @(negedge clk);
        chk("f1_pre",  pre_address_pc, 32'h0);
        chk("f1_fv",   32'(fetch_valid), 32'h1);
        chk("f1_ins",  instruction_fetch, memw(32'h0));
        chk("f1_addr", mem.imem_addr, 32'h4);
        lat = 2;

        // Two-cycle latency: one bubble, address held
        @(negedge clk);
        chk("l2_addr", mem.imem_addr, 32'h4);
        chk("l2_fv",   32'(fetch_valid), 32'h0);
        chk("l2_ins",  instruction_fetch, 32'h0);
        @(negedge clk);
        chk("l2_pre",  pre_address_pc, 32'h4);
        chk("l2_fv1",  32'(fetch_valid), 32'h1);
        chk("l2_nxt",  mem.imem_addr, 32'h8);
        branch_result = 1'b1; redirect_target = 32'h103;

        // Redirect with outstanding request -> drain stale response
        @(negedge clk);
        branch_result = 1'b0;
        chk("dr_addr", mem.imem_addr, 32'h8);
        chk("dr_fv",   32'(fetch_valid), 32'h0);
        @(negedge clk);
        chk("dr_tgt",  mem.imem_addr, 32'h100);
        chk("dr_fv1",  32'(fetch_valid), 32'h0);
        @(negedge clk);
        chk("dr_tgt2", mem.imem_addr, 32'h100);
        chk("dr_fv2",  32'(fetch_valid), 32'h0);
        @(negedge clk);
        chk("dr_pre",  pre_address_pc, 32'h100);
        chk("dr_fv3",  32'(fetch_valid), 32'h1);
        chk("dr_ins",  instruction_fetch, memw(32'h100));
        lat = 1; next_select = 1'b1; redirect_target = 32'h20;

        // Load-use stall at 0x20
        @(negedge clk);
        next_select = 1'b0;
        chk("ld_bub",  32'(fetch_valid), 32'h0);
        chk("ld_tgt",  mem.imem_addr, 32'h20);
        @(negedge clk);
        chk("ld_pre0", pre_address_pc, 32'h20);
        load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ld_pre",  pre_address_pc, 32'h20);
            chk("ld_fv",   32'(fetch_valid), 32'h1);
            chk("ld_ins",  instruction_fetch, memw(32'h20));
            chk("ld_addr", mem.imem_addr, 32'h24);
        end
        load = 1'b0;
        @(negedge clk);
        chk("ld_rel",  pre_address_pc, 32'h24);
        chk("ld_relv", 32'(fetch_valid), 32'h1);

        // Redirect and load together: redirect wins
        next_select = 1'b1; load = 1'b1; redirect_target = 32'h40;
        @(negedge clk);
        next_select = 1'b0; load = 1'b0;
        chk("rl_fv",   32'(fetch_valid), 32'h0);
        chk("rl_pre",  pre_address_pc, 32'h0);
        chk("rl_ins",  instruction_fetch, 32'h0);
        chk("rl_addr", mem.imem_addr, 32'h40);
        @(negedge clk);
        chk("rl_pre1", pre_address_pc, 32'h40);
        chk("rl_fv1",  32'(fetch_valid), 32'h1);

        // Async reset in the middle of DRAIN
        lat = 2; branch_result = 1'b1; redirect_target = 32'h80;
        @(negedge clk);
        branch_result = 1'b0;
        chk("ar_drn",  mem.imem_addr, 32'h44);
        #2 rst = 1'b1;
        #1;
        chk("ar_pre",  pre_address_pc, 32'h0);
        chk("ar_fv",   32'(fetch_valid), 32'h0);
        chk("ar_req",  32'(mem.imem_req), 32'h0);
        @(negedge clk);
        rst = 1'b0; lat = 1; force_vld = 1'b1;
        #1 chk("ar_boot", 32'(mem.imem_req), 32'h0);
`ifdef PC_FETCH_PERF_EN
        chk("ar_pfc",  perf_fetch_cnt, 32'h0);
        chk("ar_psc",  perf_stall_cnt, 32'h0);
`endif
        @(negedge clk);
        force_vld = 1'b0;
        chk("ar_fv1",  32'(fetch_valid), 32'h0);
        chk("ar_addr", mem.imem_addr, 32'h0);
        chk("ar_req1", 32'(mem.imem_req), 32'h1);
        @(negedge clk);
        chk("ar_pre1", pre_address_pc, 32'h0);
        chk("ar_fv2",  32'(fetch_valid), 32'h1);
        chk("ar_ins",  instruction_fetch, memw(32'h0));

        // Misaligned redirect near the top, then wrap to zero
        next_select = 1'b1; redirect_target = 32'hFFFF_FFFE;
        @(negedge clk);
        next_select = 1'b0;
        chk("wr_addr", mem.imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wr_pre",  pre_address_pc, 32'hFFFF_FFFC);
        chk("wr_ins",  instruction_fetch, memw(32'hFFFF_FFFC));
        chk("wr_wrap", mem.imem_addr, 32'h0);
        @(negedge clk);
        chk("wr_pre0", pre_address_pc, 32'h0);
        chk("wr_fv",   32'(fetch_valid), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
